// File: rtl/jtag_pkg.sv
// Shared JTAG constants for the shift arbiter and its client FSMs.
package jtag_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;

  // Client-side IR opcodes; the arbiter treats payloads as opaque.
  localparam logic [7:0] IR_DR_SELECT = 8'h09;
  localparam logic [7:0] IR_OP_9A     = 8'h9A;
  localparam logic [7:0] IR_OP_9D     = 8'h9D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set candidate at or after i_ptr (wrapping), as a one-hot.
module rr_pick #(
  parameter  int unsigned NUM_CLIENTS = 2,
  localparam int unsigned PTR_W       = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] i_cand,
  input  logic [PTR_W-1:0]       i_ptr,
  output logic [NUM_CLIENTS-1:0] o_winner
);

  logic [2*NUM_CLIENTS-1:0] w_dbl;
  logic [NUM_CLIENTS-1:0]   w_rot;
  logic [NUM_CLIENTS-1:0]   w_first;
  logic                     w_found;
  logic [2*NUM_CLIENTS-1:0] w_back;

  always_comb begin
    // Rotate so the pointer position lands on bit 0, pick lowest, rotate back.
    w_dbl   = {i_cand, i_cand} >> i_ptr;
    w_rot   = w_dbl[NUM_CLIENTS-1:0];
    w_first = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (w_rot[i] && !w_found) begin
        w_first[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
    w_back   = {w_first, w_first} << i_ptr;
    o_winner = w_back[2*NUM_CLIENTS-1 -: NUM_CLIENTS];
  end

endmodule

// File: rtl/jtag_shift_arbiter.sv
// Shares one jtag_shift engine between several requesters with round-robin and lock support.
module jtag_shift_arbiter
  import jtag_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_enable,
  input  logic [NUM_CLIENTS-1:0]            i_req,
  input  logic [NUM_CLIENTS-1:0]            i_lock,
  input  logic [NUM_CLIENTS-1:0]            i_mode,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] i_data_in,
  output logic [NUM_CLIENTS-1:0]            o_grant,
  output logic [NUM_CLIENTS-1:0]            o_ack,
  output logic [DATA_WIDTH-1:0]             o_data_out,
  output logic [DATA_WIDTH-1:0]             o_shift_data_in,
  output logic                              o_shift_mode,
  output logic                              o_shift_reset,
  input  logic                              i_shift_done,
  input  logic [DATA_WIDTH-1:0]             i_shift_data_out
);

  localparam int unsigned PW = $clog2(NUM_CLIENTS);

  state_e                 r_state;
  logic [NUM_CLIENTS-1:0] r_grant;
  logic [NUM_CLIENTS-1:0] r_ack;
  logic [DATA_WIDTH-1:0]  r_data_out;
  logic [DATA_WIDTH-1:0]  r_shift_data_in;
  logic                   r_shift_mode;
  logic                   r_shift_reset;
  logic [PW-1:0]          r_rr;

  logic [NUM_CLIENTS-1:0] w_cand;
  logic [NUM_CLIENTS-1:0] w_winner;
  logic [DATA_WIDTH-1:0]  w_win_data;
  logic                   w_win_mode;
  logic [PW-1:0]          w_owner_idx;
  logic [PW-1:0]          w_next_rr;
  logic                   w_owner_lock;

  always_comb begin
    // A current owner is the only candidate; otherwise everyone requesting competes.
    w_cand       = (r_grant != '0) ? (r_grant & i_req) : i_req;
    w_owner_lock = |(r_grant & i_lock);
    w_owner_idx  = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (r_grant[i]) w_owner_idx = PW'(i);
    end
    w_next_rr  = (w_owner_idx == PW'(NUM_CLIENTS - 1)) ? '0 : w_owner_idx + PW'(1);
    w_win_data = '0;
    w_win_mode = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (w_winner[i]) begin
        w_win_data = i_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        w_win_mode = i_mode[i];
      end
    end
  end

  rr_pick #(
    .NUM_CLIENTS(NUM_CLIENTS)
  ) u_rr_pick (
    .i_cand  (w_cand),
    .i_ptr   (r_rr),
    .o_winner(w_winner)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_grant         <= '0;
      r_ack           <= '0;
      r_data_out      <= '0;
      r_shift_data_in <= '0;
      r_shift_mode    <= 1'b0;
      r_shift_reset   <= 1'b1;
      r_rr            <= '0;
    end else if (i_enable) begin
      unique case (r_state)
        IDLE: begin
          if ((r_grant != '0) && !w_owner_lock) begin
            // Lock dropped while idle-but-owned: release without an ack.
            r_grant <= '0;
            r_rr    <= w_next_rr;
          end else if (w_winner != '0) begin
            r_grant         <= w_winner;
            r_shift_data_in <= w_win_data;
            r_shift_mode    <= w_win_mode;
            r_shift_reset   <= 1'b0;
            r_state         <= RUN;
          end
        end
        RUN: begin
          if (i_shift_done) begin
            r_data_out    <= i_shift_data_out;
            r_ack         <= r_grant;
            r_shift_reset <= 1'b1;
            r_state       <= ACK;
          end
        end
        ACK: begin
          r_ack <= '0;
          if (!w_owner_lock) begin
            r_grant <= '0;
            r_rr    <= w_next_rr;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_grant         = r_grant;
  // A frozen ACK cycle must not present a pulse; it is delivered once enable returns.
  assign o_ack           = r_ack & {NUM_CLIENTS{i_enable}};
  assign o_data_out      = r_data_out;
  assign o_shift_data_in = r_shift_data_in;
  assign o_shift_mode    = r_shift_mode;
  assign o_shift_reset   = r_shift_reset;

endmodule
